// File: rtl/pdp8_mem_pkg.sv
// pdp8_mem_pkg: requester indices, FSM states and width defaults for the core memory arbiter.
package pdp8_mem_pkg;
    localparam int AW_DEF       = 12;
    localparam int DW_DEF       = 12;
    localparam int LOCK_MAX_DEF = 2;
    localparam int REQ_PANEL    = 0;
    localparam int REQ_CPU      = 1;
    localparam int REQ_DMA      = 2;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2,
        LOCKED   = 2'd3
    } state_t;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: eligible mask -> one-hot winner; bit 2 beats bit 1 unless rot swaps them, bit 0 always last.
module mem_arb_pick (
    input  logic [2:0] elig,
    input  logic       rot,
    output logic [2:0] pick
);
    assign pick = (elig[2] && !(rot && elig[1])) ? 3'b100 :
                  elig[1] ? 3'b010 :
                  elig[0] ? 3'b001 : 3'b000;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: three-way single-port core RAM arbiter with locked RMW chaining.
// Define MEM_ARB_RR_EN for rotating DMA/CPU priority; default is fixed DMA > CPU > panel.
module mem_arbiter
    import pdp8_mem_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic            SYSCLK,
    input  logic            CLEAR,
    input  logic            HALTED,
    input  logic [2:0]      REQ,
    input  logic [2:0]      WE,
    input  logic [2:0]      LOCK,
    input  logic [3*AW-1:0] ADDR,
    input  logic [3*DW-1:0] WDATA,
    output logic [2:0]      ACK,
    output logic [DW-1:0]   RDATA,
    output logic [2:0]      GNT,
    output logic            BUSY,
    output logic [AW-1:0]   RAM_ADDR,
    output logic [DW-1:0]   RAM_WDATA,
    output logic            RAM_WE,
    output logic            RAM_OE,
    input  logic [DW-1:0]   RAM_RDATA
);
    localparam int CW = $clog2(LOCK_MAX + 1);
    state_t        state, state_n;
    logic [2:0]    gnt_n, pick, src;
    logic [CW-1:0] cnt, cnt_n;
    logic          we_q, load, rot, we_sel, lock_sel, req_sel;
    logic [AW-1:0] addr_sel;
    logic [DW-1:0] wdata_sel, rdata_q;

    mem_arb_pick u_pick (.elig(REQ & {2'b11, HALTED}), .rot(rot), .pick(pick));

`ifdef MEM_ARB_RR_EN
    logic rr_dma;
    // rr_dma remembers whether DMA (1) or CPU (0) was granted last
    always_ff @(posedge SYSCLK or posedge CLEAR)
        if (CLEAR) rr_dma <= 1'b0;
        else if (state == IDLE && |pick[2:1]) rr_dma <= pick[2];
    assign rot = rr_dma;
`else
    assign rot = 1'b0;
`endif

    assign src = (state == IDLE) ? pick : GNT;

    always_comb begin
        addr_sel  = '0;
        wdata_sel = '0;
        we_sel    = 1'b0;
        lock_sel  = 1'b0;
        req_sel   = 1'b0;
        for (int i = 0; i < 3; i++)
            if (src[i]) begin
                addr_sel  = ADDR[i*AW +: AW];
                wdata_sel = WDATA[i*DW +: DW];
                we_sel    = WE[i];
                lock_sel  = LOCK[i];
                req_sel   = REQ[i];
            end
    end

    always_comb begin
        state_n = state;
        gnt_n   = GNT;
        cnt_n   = cnt;
        load    = 1'b0;
        case (state)
            IDLE: if (|pick) begin
                state_n = ACCESS;
                gnt_n   = pick;
                load    = 1'b1;
            end
            ACCESS: state_n = COMPLETE;
            COMPLETE: if (lock_sel && int'(cnt) + 1 < LOCK_MAX) begin
                state_n = LOCKED;
                cnt_n   = cnt + 1'b1;
            end else begin
                state_n = IDLE;
                cnt_n   = '0;
                gnt_n   = '0;
            end
            LOCKED: if (req_sel) begin
                state_n = ACCESS;
                load    = 1'b1;
            end else if (!lock_sel) begin
                state_n = IDLE;
                cnt_n   = '0;
                gnt_n   = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge SYSCLK or posedge CLEAR)
        if (CLEAR) begin
            state     <= IDLE;
            GNT       <= '0;
            cnt       <= '0;
            RAM_ADDR  <= '0;
            RAM_WDATA <= '0;
            we_q      <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state <= state_n;
            GNT   <= gnt_n;
            cnt   <= cnt_n;
            if (load) begin
                RAM_ADDR  <= addr_sel;
                RAM_WDATA <= wdata_sel;
                we_q      <= we_sel;
            end
            if (state == COMPLETE && !we_q) rdata_q <= RAM_RDATA;
        end

    // strobes and ACK decode from registered state so CLEAR kills them at once
    assign RAM_WE = (state == ACCESS) && we_q;
    assign RAM_OE = (state == ACCESS) && !we_q;
    assign ACK    = (state == COMPLETE) ? GNT : 3'b000;
    assign RDATA  = (state == COMPLETE && !we_q) ? RAM_RDATA : rdata_q;
    assign BUSY   = (state != IDLE);
endmodule
